// File: rtl/spi_reg_responder.sv
// SPI register responder: command/address/data frames over an oversampled SPI link,
// with an N_REG x 8 register file, idle-timeout abort and a registered backdoor read port.
module spi_reg_responder #(
  parameter int N_REG        = 64,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       serial_in,
  output logic       serial_out,
  output logic       write_strobe,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  output logic       read_active,
  output logic       frame_abort,
  input  logic [7:0] bd_addr,
  output logic [7:0] bd_data
);

  // state  | meaning
  // CMD    | receiving command byte (bit7: 1=write, 0=read)
  // ADDR   | receiving register address
  // WDATA  | receiving write data, commit on last bit
  // COUNT  | receiving read byte count
  // RDATA  | shifting read data out, serial_in ignored
  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_COUNT = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  localparam int          AW       = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int          TW       = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [8:0]  N_REG9   = 9'(N_REG);
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

  logic          sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic          sin_s1_q, sin_s2_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_in_q, shift_in_d;
  logic          is_write_q, is_write_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [7:0]    sout_q, sout_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          write_strobe_q, write_strobe_d;
  logic [7:0]    write_addr_q, write_addr_d;
  logic [7:0]    write_data_q, write_data_d;
  logic          frame_abort_q, frame_abort_d;
  logic [7:0]    bd_data_q, bd_data_d;
  logic [7:0]    mem_q [N_REG];
  logic [7:0]    mem_d [N_REG];

  logic       rise, fall, tmo_active;
  logic [7:0] rx_byte, rd_byte;

  always_comb begin
    rise       = sclk_s2_q & ~sclk_s3_q;
    fall       = ~sclk_s2_q & sclk_s3_q;
    rx_byte    = {shift_in_q, sin_s2_q};
    tmo_active = (state_q != ST_CMD) || (bit_cnt_q != 3'd0);
    rd_byte    = ({1'b0, ptr_q} < N_REG9) ? mem_q[ptr_q[AW-1:0]] : 8'h00;
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_in_d     = shift_in_q;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    ptr_d          = ptr_q;
    remaining_d    = remaining_q;
    sout_d         = sout_q;
    tmo_d          = tmo_q;
    write_strobe_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    frame_abort_d  = 1'b0;
    mem_d          = mem_q;
    bd_data_d      = ({1'b0, bd_addr} < N_REG9) ? mem_q[bd_addr[AW-1:0]] : 8'h00;

    // Any edge restarts the idle window, so a rise always wins over a timeout.
    if (rise || fall) begin
      tmo_d = '0;
    end else if (tmo_active) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d         = '0;
        frame_abort_d = 1'b1;
        bit_cnt_d     = 3'd0;
        state_d       = ST_CMD;
        sout_d        = 8'h00;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (rise) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      shift_in_d = rx_byte[6:0];
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          ST_CMD: begin
            is_write_d = rx_byte[7];
            state_d    = ST_ADDR;
          end
          ST_ADDR: begin
            addr_d  = rx_byte;
            state_d = is_write_q ? ST_WDATA : ST_COUNT;
          end
          ST_WDATA: begin
            if ({1'b0, addr_q} < N_REG9) begin
              mem_d[addr_q[AW-1:0]] = rx_byte;
            end
            write_strobe_d = 1'b1;
            write_addr_d   = addr_q;
            write_data_d   = rx_byte;
            state_d        = ST_CMD;
          end
          ST_COUNT: begin
            if (rx_byte == 8'h00) begin
              state_d = ST_CMD;
            end else begin
              ptr_d       = addr_q;
              remaining_d = rx_byte;
              sout_d      = 8'h00;
              state_d     = ST_RDATA;
            end
          end
          ST_RDATA: begin
            ptr_d       = ptr_q + 8'd1;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              sout_d  = 8'h00;
              state_d = ST_CMD;
            end
          end
          default: state_d = ST_CMD;
        endcase
      end
    end

    if (fall && (state_q == ST_RDATA)) begin
      sout_d = (bit_cnt_q == 3'd0) ? rd_byte : {sout_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q      <= 1'b0;
      sclk_s2_q      <= 1'b0;
      sclk_s3_q      <= 1'b0;
      sin_s1_q       <= 1'b0;
      sin_s2_q       <= 1'b0;
      state_q        <= ST_CMD;
      bit_cnt_q      <= 3'd0;
      shift_in_q     <= 7'd0;
      is_write_q     <= 1'b0;
      addr_q         <= 8'h00;
      ptr_q          <= 8'h00;
      remaining_q    <= 8'h00;
      sout_q         <= 8'h00;
      tmo_q          <= '0;
      write_strobe_q <= 1'b0;
      write_addr_q   <= 8'h00;
      write_data_q   <= 8'h00;
      frame_abort_q  <= 1'b0;
      bd_data_q      <= 8'h00;
      for (int i = 0; i < N_REG; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sclk_s1_q      <= spi_clk;
      sclk_s2_q      <= sclk_s1_q;
      sclk_s3_q      <= sclk_s2_q;
      sin_s1_q       <= serial_in;
      sin_s2_q       <= sin_s1_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_in_q     <= shift_in_d;
      is_write_q     <= is_write_d;
      addr_q         <= addr_d;
      ptr_q          <= ptr_d;
      remaining_q    <= remaining_d;
      sout_q         <= sout_d;
      tmo_q          <= tmo_d;
      write_strobe_q <= write_strobe_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      frame_abort_q  <= frame_abort_d;
      bd_data_q      <= bd_data_d;
      mem_q          <= mem_d;
    end
  end

  assign serial_out   = (state_q == ST_RDATA) ? sout_q[7] : 1'b0;
  assign read_active  = (state_q == ST_RDATA);
  assign write_strobe = write_strobe_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign frame_abort  = frame_abort_q;
  assign bd_data      = bd_data_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: bit-banged SPI master, frame-level register model,
// directed boundary cases plus randomized write/read frames.
module tb_spi_reg_responder;

  localparam int N_REG        = 64;
  localparam int IDLE_TIMEOUT = 256;
  localparam int PH           = 8;

  logic       clk = 1'b0;
  logic       rst, spi_clk, serial_in;
  logic       serial_out, write_strobe, read_active, frame_abort;
  logic [7:0] write_addr, write_data, bd_addr, bd_data;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int abort_cnt = 0;
  int sout_hi_cnt = 0;
  logic [7:0] bd_at_strobe = 8'h00;
  logic [7:0] model_mem [256];

  spi_reg_responder #(.N_REG(N_REG), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .serial_in(serial_in),
    .serial_out(serial_out), .write_strobe(write_strobe), .write_addr(write_addr),
    .write_data(write_data), .read_active(read_active), .frame_abort(frame_abort),
    .bd_addr(bd_addr), .bd_data(bd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_strobe) begin
      strobe_cnt   <= strobe_cnt + 1;
      bd_at_strobe <= bd_data;
    end
    if (frame_abort) abort_cnt <= abort_cnt + 1;
    if (serial_out) sout_hi_cnt <= sout_hi_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int a);
    return (a < N_REG) ? model_mem[a] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic smp);
    serial_in = b;
    repeat (PH) @(negedge clk);
    smp = serial_out;
    spi_clk = 1'b1;
    repeat (PH) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    d = bd_data;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic [7:0] rx;
    int s0;
    s0 = strobe_cnt;
    spi_byte({1'b1, 7'($urandom)}, rx);
    spi_byte(a, rx);
    spi_byte(d, rx);
    idle(2);
    check({tag, ".strobes"}, 32'(strobe_cnt - s0), 32'd1);
    check({tag, ".waddr"}, {24'd0, write_addr}, {24'd0, a});
    check({tag, ".wdata"}, {24'd0, write_data}, {24'd0, d});
    if (int'(a) < N_REG) model_mem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input string tag);
    logic [7:0] rx;
    spi_byte({1'b0, 7'($urandom)}, rx);
    spi_byte(a, rx);
    spi_byte(8'(n), rx);
    if (n > 0) check({tag, ".ractive_on"}, {31'd0, read_active}, 32'd1);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), rx);
      check($sformatf("%s.byte%0d", tag, i), {24'd0, rx},
            {24'd0, model_rd((int'(a) + i) % 256)});
    end
    idle(2);
    check({tag, ".ractive_off"}, {31'd0, read_active}, 32'd0);
    check({tag, ".sout_idle"}, {31'd0, serial_out}, 32'd0);
  endtask

  initial begin
    logic [7:0] d, rx, a;
    logic b;
    int s0, a0, h0, nerr;

    model_clear();
    rst = 1'b1; spi_clk = 1'b0; serial_in = 1'b0; bd_addr = 8'h00;
    idle(5);
    check("rst.serial_out", {31'd0, serial_out}, 32'd0);
    check("rst.write_strobe", {31'd0, write_strobe}, 32'd0);
    check("rst.write_addr", {24'd0, write_addr}, 32'd0);
    check("rst.write_data", {24'd0, write_data}, 32'd0);
    check("rst.read_active", {31'd0, read_active}, 32'd0);
    check("rst.frame_abort", {31'd0, frame_abort}, 32'd0);
    check("rst.bd_data", {24'd0, bd_data}, 32'd0);
    rst = 1'b0;
    idle(3);

    // Basic write and backdoor readback
    do_write(8'h05, 8'h3C, "w05");
    bd_read(8'h05, d);
    check("w05.bd", {24'd0, d}, 32'h3C);

    // Backdoor of the register being written returns the pre-write value that cycle
    bd_addr = 8'h05;
    do_write(8'h05, 8'hC3, "w05b");
    check("bd_same_cycle_old", {24'd0, bd_at_strobe}, 32'h3C);
    check("bd_next_cycle_new", {24'd0, bd_data}, 32'hC3);

    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      do_write(a, 8'($urandom), $sformatf("rw%0d", i));
    end
    nerr = 0;
    for (int i = 0; i < 66; i++) begin
      bd_read(8'(i), d);
      if (d !== model_rd(i)) nerr++;
    end
    check("bd_sweep_mismatches", 32'(nerr), 32'd0);
    bd_read(8'hFF, d);
    check("bd_ff_zero", {24'd0, d}, 32'd0);

    // Two-byte read
    do_write(8'h03, 8'h11, "w03");
    do_write(8'h04, 8'h22, "w04");
    do_read(8'h03, 2, "r03");

    // Pointer wraps at 256, not at N_REG
    do_write(8'h00, 8'hAA, "w00");
    do_read(8'h3F, 2, "r3f");
    do_read(8'hFF, 2, "rff");

    for (int i = 0; i < 6; i++) begin
      do_read(8'($urandom_range(0, 255)), $urandom_range(1, 4), $sformatf("rr%0d", i));
    end

    // N=0: no data phase, next byte is a command
    h0 = sout_hi_cnt;
    spi_byte(8'h00, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    idle(2);
    check("n0.read_active", {31'd0, read_active}, 32'd0);
    check("n0.sout_high_cycles", 32'(sout_hi_cnt - h0), 32'd0);
    do_write(8'h09, 8'h5A, "n0.follow");

    // Partial write aborted by timeout
    s0 = strobe_cnt; a0 = abort_cnt;
    spi_byte(8'h80, rx);
    spi_byte(8'h07, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    idle(IDLE_TIMEOUT - 16);
    check("tmo.no_early_abort", 32'(abort_cnt - a0), 32'd0);
    idle(40);
    check("tmo.abort_pulse", 32'(abort_cnt - a0), 32'd1);
    check("tmo.no_strobe", 32'(strobe_cnt - s0), 32'd0);
    idle(IDLE_TIMEOUT + 40);
    check("tmo.no_abort_in_idle", 32'(abort_cnt - a0), 32'd1);
    bd_read(8'h07, d);
    check("tmo.reg7_kept", {24'd0, d}, {24'd0, model_rd(7)});
    do_write(8'h07, 8'h96, "tmo.follow");
    bd_read(8'h07, d);
    check("tmo.reg7_new", {24'd0, d}, 32'h96);

    // Timeout during a read data phase
    do_write(8'h10, 8'hFF, "w10");
    a0 = abort_cnt;
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
    idle(IDLE_TIMEOUT + 20);
    check("rtmo.abort_pulse", 32'(abort_cnt - a0), 32'd1);
    check("rtmo.serial_out", {31'd0, serial_out}, 32'd0);
    check("rtmo.read_active", {31'd0, read_active}, 32'd0);
    do_read(8'h10, 1, "rtmo.follow");

    // Reset in the middle of a read data byte
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h03, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    rst = 1'b1;
    idle(3);
    check("mrst.serial_out", {31'd0, serial_out}, 32'd0);
    check("mrst.read_active", {31'd0, read_active}, 32'd0);
    rst = 1'b0;
    model_clear();
    idle(3);
    nerr = 0;
    for (int i = 0; i < N_REG; i++) begin
      bd_read(8'(i), d);
      if (d !== 8'h00) nerr++;
    end
    check("mrst.regs_cleared", 32'(nerr), 32'd0);
    do_write(8'h21, 8'h7E, "mrst.follow");
    bd_read(8'h21, d);
    check("mrst.bd21", {24'd0, d}, 32'h7E);
    do_read(8'h20, 3, "mrst.read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
